// File: rtl/vx_fpu_csr_file_pkg.sv
// Shared definitions for the FPU CSR responder: CSR addresses, op encodings,
// exception-flag layout, rounding-mode constants and the request FSM states.
package vx_fpu_csr_file_pkg;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        CSR_OP_RW   = 2'd0,
        CSR_OP_RS   = 2'd1,
        CSR_OP_RC   = 2'd2,
        CSR_OP_RSVD = 2'd3
    } csr_op_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [2:0] FRM_RNE = 3'd0;
    localparam logic [2:0] FRM_RTZ = 3'd1;
    localparam logic [2:0] FRM_RDN = 3'd2;
    localparam logic [2:0] FRM_RUP = 3'd3;
    localparam logic [2:0] FRM_RMM = 3'd4;
    localparam logic [2:0] FRM_DYN = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RSP   = 2'd3
    } csr_state_e;

    // Accesses that observe fflags must wait for in-flight ops to retire.
    function automatic logic addr_needs_drain(input logic [11:0] addr);
        return (addr == CSR_FFLAGS) || (addr == CSR_FCSR);
    endfunction

endpackage

// File: rtl/vx_fpu_pending_ctr.sv
// Per-warp count of FPU ops in flight; saturates at 0 and PENDING_SIZE and
// flags over/underflow with assertions.
module vx_fpu_pending_ctr #(
    parameter int NUM_WARPS    = 4,
    parameter int PENDING_SIZE = 8,
    parameter int NW_WIDTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_inc_valid,
    input  logic [NW_WIDTH-1:0]  i_inc_wid,
    input  logic                 i_dec_valid,
    input  logic [NW_WIDTH-1:0]  i_dec_wid,
    output logic [NUM_WARPS-1:0] o_zero
);

    localparam int PW = $clog2(PENDING_SIZE + 1);
    localparam logic [PW-1:0] CNT_MAX = PW'(PENDING_SIZE);

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
        logic [PW-1:0] r_cnt;
        logic          w_inc;
        logic          w_dec;

        assign w_inc     = i_inc_valid && (i_inc_wid == NW_WIDTH'(g));
        assign w_dec     = i_dec_valid && (i_dec_wid == NW_WIDTH'(g));
        assign o_zero[g] = (r_cnt == '0);

        // Issue and retire on the same warp in one cycle cancel out.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                assert (r_cnt != CNT_MAX);
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + PW'(1);
            end else if (w_dec && !w_inc) begin
                assert (r_cnt != '0);
                if (r_cnt != '0) r_cnt <= r_cnt - PW'(1);
            end
        end
    end

endmodule

// File: rtl/vx_fpu_csr_file.sv
// Per-warp fflags/frm storage with zero-latency frm lookup, FPU flag
// accumulation and a stalling CSR instruction engine.
//
// state | meaning
// IDLE  | ready for a CSR request
// DRAIN | wait until the warp has no FPU ops in flight (fflags/fcsr only)
// EXEC  | read old value, merge same-cycle write-back, commit new value
// RSP   | hold response until accepted
module vx_fpu_csr_file
    import vx_fpu_csr_file_pkg::*;
#(
    parameter int NUM_WARPS    = 4,
    parameter int PENDING_SIZE = 8,
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NW_WIDTH-1:0] i_fpu_read_wid,
    output logic [2:0]          o_fpu_read_frm,
    input  logic                i_fpu_write_enable,
    input  logic [NW_WIDTH-1:0] i_fpu_write_wid,
    input  logic [4:0]          i_fpu_write_fflags,
    input  logic                i_fpu_issue_valid,
    input  logic [NW_WIDTH-1:0] i_fpu_issue_wid,
    input  logic                i_fpu_done_valid,
    input  logic [NW_WIDTH-1:0] i_fpu_done_wid,
    input  logic                i_csr_req_valid,
    output logic                o_csr_req_ready,
    input  logic [NW_WIDTH-1:0] i_csr_req_wid,
    input  logic [11:0]         i_csr_req_addr,
    input  logic [1:0]          i_csr_req_op,
    input  logic                i_csr_req_write,
    input  logic [31:0]         i_csr_req_wdata,
    output logic                o_csr_rsp_valid,
    output logic [31:0]         o_csr_rsp_rdata,
    input  logic                i_csr_rsp_ready
);

    csr_state_e          r_state, w_state_nxt;
    fflags_t             r_fflags [NUM_WARPS];
    logic [2:0]          r_frm    [NUM_WARPS];
    logic [NW_WIDTH-1:0] r_wid;
    logic [11:0]         r_addr;
    csr_op_e             r_op;
    logic                r_write;
    logic [7:0]          r_wdata;
    logic [31:0]         r_rsp_rdata;

    logic [NUM_WARPS-1:0] w_zero;
    logic                 w_fire;
    logic                 w_drained;
    logic                 w_wb_hit;
    fflags_t              w_ff_old;
    logic [7:0]           w_old;
    logic [7:0]           w_new;
    logic                 w_commit;
    logic                 w_unused;

    vx_fpu_pending_ctr #(
        .NUM_WARPS    (NUM_WARPS),
        .PENDING_SIZE (PENDING_SIZE),
        .NW_WIDTH     (NW_WIDTH)
    ) u_pending (
        .clk         (clk),
        .reset       (reset),
        .i_inc_valid (i_fpu_issue_valid),
        .i_inc_wid   (i_fpu_issue_wid),
        .i_dec_valid (i_fpu_done_valid),
        .i_dec_wid   (i_fpu_done_wid),
        .o_zero      (w_zero)
    );

    assign o_fpu_read_frm  = r_frm[i_fpu_read_wid];
    assign o_csr_req_ready = (r_state == ST_IDLE);
    assign o_csr_rsp_valid = (r_state == ST_RSP);
    assign o_csr_rsp_rdata = r_rsp_rdata;
    assign w_fire          = i_csr_req_valid && o_csr_req_ready;
    assign w_unused        = ^i_csr_req_wdata[31:8];

    // A retirement in this very cycle still has flags to land next edge.
    assign w_drained = !addr_needs_drain(r_addr) ||
                       (w_zero[r_wid] && !(i_fpu_done_valid && (i_fpu_done_wid == r_wid)));

    assign w_wb_hit = i_fpu_write_enable && (i_fpu_write_wid == r_wid);
    assign w_ff_old = r_fflags[r_wid] | (w_wb_hit ? i_fpu_write_fflags : 5'd0);

    always_comb begin
        w_old = 8'd0;
        case (r_addr)
            CSR_FFLAGS: w_old = {3'd0, w_ff_old};
            CSR_FRM:    w_old = {5'd0, r_frm[r_wid]};
            CSR_FCSR:   w_old = {r_frm[r_wid], w_ff_old};
            default:    w_old = 8'd0;
        endcase
    end

    always_comb begin
        w_new = w_old;
        case (r_op)
            CSR_OP_RW: w_new = r_wdata;
            CSR_OP_RS: w_new = w_old | r_wdata;
            CSR_OP_RC: w_new = w_old & ~r_wdata;
            default:   w_new = w_old;
        endcase
    end

    assign w_commit = (r_state == ST_EXEC) && r_write && (r_op != CSR_OP_RSVD);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_fire) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drained) w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = ST_RSP;
            ST_RSP:   if (i_csr_rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_fflags[w] <= '0;
                r_frm[w]    <= FRM_RNE;
            end
            r_wid       <= '0;
            r_addr      <= '0;
            r_op        <= CSR_OP_RW;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (w_commit && (r_wid == NW_WIDTH'(w)) && addr_needs_drain(r_addr))
                    r_fflags[w] <= w_new[4:0];
                else if (i_fpu_write_enable && (i_fpu_write_wid == NW_WIDTH'(w)))
                    r_fflags[w] <= r_fflags[w] | i_fpu_write_fflags;

                if (w_commit && (r_wid == NW_WIDTH'(w))) begin
                    if (r_addr == CSR_FRM)       r_frm[w] <= w_new[2:0];
                    else if (r_addr == CSR_FCSR) r_frm[w] <= w_new[7:5];
                end
            end
            if (w_fire) begin
                r_wid   <= i_csr_req_wid;
                r_addr  <= i_csr_req_addr;
                r_op    <= csr_op_e'(i_csr_req_op);
                r_write <= i_csr_req_write;
                r_wdata <= i_csr_req_wdata[7:0];
            end
            if (r_state == ST_EXEC) r_rsp_rdata <= {24'd0, w_old};
        end
    end

endmodule

// File: tb/tb_vx_fpu_csr_file.sv
// Directed bench for vx_fpu_csr_file: CSR ops, flag accumulation, drain
// stalls, response backpressure and reset mid-request.
module tb_vx_fpu_csr_file;
    import vx_fpu_csr_file_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  i_fpu_read_wid;
    logic [2:0]  o_fpu_read_frm;
    logic        i_fpu_write_enable;
    logic [1:0]  i_fpu_write_wid;
    logic [4:0]  i_fpu_write_fflags;
    logic        i_fpu_issue_valid;
    logic [1:0]  i_fpu_issue_wid;
    logic        i_fpu_done_valid;
    logic [1:0]  i_fpu_done_wid;
    logic        i_csr_req_valid;
    logic        o_csr_req_ready;
    logic [1:0]  i_csr_req_wid;
    logic [11:0] i_csr_req_addr;
    logic [1:0]  i_csr_req_op;
    logic        i_csr_req_write;
    logic [31:0] i_csr_req_wdata;
    logic        o_csr_rsp_valid;
    logic [31:0] o_csr_rsp_rdata;
    logic        i_csr_rsp_ready;

    int n_total = 0;
    int n_bad   = 0;

    vx_fpu_csr_file dut (
        .clk                (clk),
        .reset              (reset),
        .i_fpu_read_wid     (i_fpu_read_wid),
        .o_fpu_read_frm     (o_fpu_read_frm),
        .i_fpu_write_enable (i_fpu_write_enable),
        .i_fpu_write_wid    (i_fpu_write_wid),
        .i_fpu_write_fflags (i_fpu_write_fflags),
        .i_fpu_issue_valid  (i_fpu_issue_valid),
        .i_fpu_issue_wid    (i_fpu_issue_wid),
        .i_fpu_done_valid   (i_fpu_done_valid),
        .i_fpu_done_wid     (i_fpu_done_wid),
        .i_csr_req_valid    (i_csr_req_valid),
        .o_csr_req_ready    (o_csr_req_ready),
        .i_csr_req_wid      (i_csr_req_wid),
        .i_csr_req_addr     (i_csr_req_addr),
        .i_csr_req_op       (i_csr_req_op),
        .i_csr_req_write    (i_csr_req_write),
        .i_csr_req_wdata    (i_csr_req_wdata),
        .o_csr_rsp_valid    (o_csr_rsp_valid),
        .o_csr_rsp_rdata    (o_csr_rsp_rdata),
        .i_csr_rsp_ready    (i_csr_rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_issue(input logic [1:0] wid, input logic [11:0] addr, input logic [1:0] op,
                             input logic wr, input logic [31:0] wd);
        chk_val("req_ready_idle", {31'd0, o_csr_req_ready}, 32'd1);
        i_csr_req_valid = 1'b1;
        i_csr_req_wid   = wid;
        i_csr_req_addr  = addr;
        i_csr_req_op    = op;
        i_csr_req_write = wr;
        i_csr_req_wdata = wd;
        tick();
        i_csr_req_valid = 1'b0;
    endtask

    // Called one cycle after acceptance; lat counts cycles from acceptance.
    task automatic csr_wait(output logic [31:0] rd, output int lat);
        lat = 1;
        while (!o_csr_rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!o_csr_rsp_valid) chk_val("rsp_timeout", {31'd0, o_csr_rsp_valid}, 32'd1);
        rd = o_csr_rsp_rdata;
    endtask

    task automatic csr_do(input string tag, input logic [1:0] wid, input logic [11:0] addr,
                          input logic [1:0] op, input logic wr, input logic [31:0] wd,
                          input logic [31:0] exp);
        logic [31:0] rd;
        int          lat;
        csr_issue(wid, addr, op, wr, wd);
        csr_wait(rd, lat);
        chk_val(tag, rd, exp);
        chk_val({tag, "_lat"}, lat, 32'd3);
        tick();
    endtask

    task automatic fpu_wb(input logic [1:0] wid, input logic [4:0] flags);
        i_fpu_write_enable = 1'b1;
        i_fpu_write_wid    = wid;
        i_fpu_write_fflags = flags;
        tick();
        i_fpu_write_enable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;

        reset = 1'b1;
        i_fpu_read_wid = 2'd0;
        i_fpu_write_enable = 1'b0; i_fpu_write_wid = 2'd0; i_fpu_write_fflags = 5'd0;
        i_fpu_issue_valid = 1'b0;  i_fpu_issue_wid = 2'd0;
        i_fpu_done_valid = 1'b0;   i_fpu_done_wid = 2'd0;
        i_csr_req_valid = 1'b0; i_csr_req_wid = 2'd0; i_csr_req_addr = 12'd0;
        i_csr_req_op = 2'd0; i_csr_req_write = 1'b0; i_csr_req_wdata = 32'd0;
        i_csr_rsp_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        chk_val("rst_req_ready", {31'd0, o_csr_req_ready}, 32'd1);
        chk_val("rst_rsp_valid", {31'd0, o_csr_rsp_valid}, 32'd0);
        chk_val("rst_rsp_rdata", o_csr_rsp_rdata, 32'd0);
        chk_val("rst_frm", {29'd0, o_fpu_read_frm}, 32'd0);

        csr_do("fcsr_rd_w2", 2'd2, CSR_FCSR, CSR_OP_RS, 1'b0, 32'd0, 32'h00);
        chk_val("rsp_drop", {31'd0, o_csr_rsp_valid}, 32'd0);
        chk_val("ready_back", {31'd0, o_csr_req_ready}, 32'd1);

        // Flag accumulation is per warp.
        fpu_wb(2'd1, 5'h01);
        fpu_wb(2'd1, 5'h04);
        csr_do("ff_w1_acc", 2'd1, CSR_FFLAGS, CSR_OP_RS, 1'b0, 32'd0, 32'h05);
        csr_do("ff_w0_clean", 2'd0, CSR_FFLAGS, CSR_OP_RS, 1'b0, 32'd0, 32'h00);

        // Write-back landing in the EXEC cycle is merged into the old value.
        csr_issue(2'd1, CSR_FFLAGS, CSR_OP_RS, 1'b0, 32'd0);
        tick();
        i_fpu_write_enable = 1'b1; i_fpu_write_wid = 2'd1; i_fpu_write_fflags = 5'h02;
        tick();
        i_fpu_write_enable = 1'b0;
        chk_val("exec_merge_valid", {31'd0, o_csr_rsp_valid}, 32'd1);
        chk_val("exec_merge_rdata", o_csr_rsp_rdata, 32'h07);
        tick();
        csr_do("ff_w1_after_merge", 2'd1, CSR_FFLAGS, CSR_OP_RS, 1'b0, 32'd0, 32'h07);

        // Drain stall: three ops in flight on wid0.
        i_fpu_issue_valid = 1'b1; i_fpu_issue_wid = 2'd0;
        repeat (3) tick();
        i_fpu_issue_valid = 1'b0;
        csr_issue(2'd0, CSR_FFLAGS, CSR_OP_RS, 1'b0, 32'd0);
        for (int d = 0; d < 3; d++) begin
            repeat (2) begin
                tick();
                chk_val("drain_stall", {31'd0, o_csr_rsp_valid}, 32'd0);
            end
            chk_val("drain_not_ready", {31'd0, o_csr_req_ready}, 32'd0);
            i_fpu_done_valid = 1'b1; i_fpu_done_wid = 2'd0;
            if (d == 2) begin
                i_fpu_write_enable = 1'b1; i_fpu_write_wid = 2'd0; i_fpu_write_fflags = 5'h10;
            end
            tick();
            i_fpu_done_valid = 1'b0;
            i_fpu_write_enable = 1'b0;
        end
        csr_wait(rd, lat);
        chk_val("drain_rdata", rd, 32'h10);
        chk_val("drain_lat", lat, 32'd3);
        tick();

        // Same-wid issue+done cancels; different wids update independently.
        i_fpu_issue_valid = 1'b1; i_fpu_issue_wid = 2'd1;
        tick();
        i_fpu_done_valid = 1'b1; i_fpu_done_wid = 2'd1;
        tick();
        i_fpu_issue_wid = 2'd2;
        tick();
        i_fpu_issue_valid = 1'b0; i_fpu_done_valid = 1'b0;
        csr_do("w1_drained", 2'd1, CSR_FFLAGS, CSR_OP_RS, 1'b0, 32'd0, 32'h07);
        csr_issue(2'd2, CSR_FCSR, CSR_OP_RS, 1'b0, 32'd0);
        repeat (2) begin
            tick();
            chk_val("w2_stall", {31'd0, o_csr_rsp_valid}, 32'd0);
        end
        i_fpu_done_valid = 1'b1; i_fpu_done_wid = 2'd2;
        tick();
        i_fpu_done_valid = 1'b0;
        csr_wait(rd, lat);
        chk_val("w2_rdata", rd, 32'h00);
        chk_val("w2_lat", lat, 32'd3);
        tick();

        // frm write visible on the lookup port the cycle after EXEC.
        i_fpu_read_wid = 2'd3;
        csr_issue(2'd3, CSR_FRM, CSR_OP_RW, 1'b1, 32'h2);
        tick();
        chk_val("frm_exec_old", {29'd0, o_fpu_read_frm}, 32'd0);
        tick();
        chk_val("frm_after_exec", {29'd0, o_fpu_read_frm}, 32'd2);
        chk_val("frm_rw_rdata", o_csr_rsp_rdata, 32'd0);
        i_fpu_read_wid = 2'd0;
        #1;
        chk_val("frm_w0_untouched", {29'd0, o_fpu_read_frm}, 32'd0);
        i_fpu_read_wid = 2'd3;
        tick();

        csr_do("fcsr_rw", 2'd3, CSR_FCSR, CSR_OP_RW, 1'b1, 32'hE3, 32'h40);
        chk_val("fcsr_frm7", {29'd0, o_fpu_read_frm}, 32'd7);
        csr_do("ff_rc", 2'd3, CSR_FFLAGS, CSR_OP_RC, 1'b1, 32'h01, 32'h03);
        csr_do("fcsr_after_rc", 2'd3, CSR_FCSR, CSR_OP_RS, 1'b0, 32'd0, 32'hE2);
        csr_do("unknown_addr", 2'd3, 12'h7C0, CSR_OP_RW, 1'b1, 32'hFF, 32'h00);
        csr_do("rsvd_op", 2'd3, CSR_FRM, CSR_OP_RSVD, 1'b1, 32'h0, 32'h07);
        csr_do("rs_frm_set", 2'd3, CSR_FRM, CSR_OP_RS, 1'b0, 32'h0, 32'h07);
        csr_do("fcsr_intact", 2'd3, CSR_FCSR, CSR_OP_RS, 1'b0, 32'd0, 32'hE2);

        // Response backpressure.
        i_csr_rsp_ready = 1'b0;
        csr_issue(2'd3, CSR_FCSR, CSR_OP_RS, 1'b0, 32'd0);
        csr_wait(rd, lat);
        repeat (5) begin
            tick();
            chk_val("hold_valid", {31'd0, o_csr_rsp_valid}, 32'd1);
            chk_val("hold_rdata", o_csr_rsp_rdata, 32'hE2);
            chk_val("hold_not_ready", {31'd0, o_csr_req_ready}, 32'd0);
        end
        i_csr_rsp_ready = 1'b1;
        tick();
        chk_val("hold_release_valid", {31'd0, o_csr_rsp_valid}, 32'd0);
        chk_val("hold_release_ready", {31'd0, o_csr_req_ready}, 32'd1);

        // Reset while stuck in DRAIN.
        i_fpu_issue_valid = 1'b1; i_fpu_issue_wid = 2'd2;
        repeat (2) tick();
        i_fpu_issue_valid = 1'b0;
        csr_issue(2'd2, CSR_FFLAGS, CSR_OP_RW, 1'b1, 32'h1F);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_val("rst_drain_ready", {31'd0, o_csr_req_ready}, 32'd1);
        chk_val("rst_drain_valid", {31'd0, o_csr_rsp_valid}, 32'd0);
        chk_val("rst_drain_rdata", o_csr_rsp_rdata, 32'd0);
        chk_val("rst_drain_frm", {29'd0, o_fpu_read_frm}, 32'd0);
        repeat (3) begin
            tick();
            chk_val("rst_no_rsp", {31'd0, o_csr_rsp_valid}, 32'd0);
        end
        csr_do("rst_ctr_zero", 2'd2, CSR_FFLAGS, CSR_OP_RS, 1'b0, 32'd0, 32'h00);
        csr_do("rst_w1_ff", 2'd1, CSR_FFLAGS, CSR_OP_RS, 1'b0, 32'd0, 32'h00);
        csr_do("rst_w3_fcsr", 2'd3, CSR_FCSR, CSR_OP_RS, 1'b0, 32'd0, 32'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
